pong_game_controller: RTL
=========================

# pong_game_controller

Game-flow sequencer for the Pong datapath: owns the match state (idle, serve countdown, rally, point hold, pause, game over) and both 3-bit scores. It gates ball and paddle motion, requests ball re-centring, and picks serve direction. It sits between the keypad decoders (`keys_1/2`, `keypressed_1/2`) and the image generator's ball/paddle logic, which reports misses back as pulses.

## Interface
- `WIN_SCORE`, 7: points to win; legal range 1..7.
- `SERVE_DELAY_FRAMES`, 60: frames counted in SERVE before the ball is released; legal range 0..255.
- `POINT_HOLD_FRAMES`, 30: frames the board freezes after a point; legal range 0..255.
- `PAUSE_KEY`, 4'd5: key code that toggles pause.
- `CLOCK_25`  in  1  25 MHz pixel clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `keys_1`  in  4  player 1 key code.
- `keypressed_1`  in  1  player 1 key valid (level).
- `keys_2`  in  4  player 2 key code.
- `keypressed_2`  in  1  player 2 key valid (level).
- `miss_left`  in  1  pulse: ball passed player 1.
- `miss_right`  in  1  pulse: ball passed player 2.
- `run`  out  1  ball may move.
- `paddle_en`  out  1  paddles may move.
- `ball_reset`  out  1  one-cycle pulse: re-centre ball.
- `serve_left`  out  1  next serve direction; 1 = toward player 1.
- `score_1`  out  3  player 1 score.
- `score_2`  out  3  player 2 score.
- `winner`  out  2  00 none, 01 player 1, 10 player 2.
- `state`  out  3  0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 PAUSE, 5 OVER.

## Operation
- Key event = rising edge of `keypressed_x`; each edge detector keeps one previous-value flop per player.
- Any event = event from either player. Events from both players in the same cycle count as one event.
- Pause event = a key event whose `keys_x` equals `PAUSE_KEY`.
- One 8-bit frame counter. It decrements only on `frame_tick` in SERVE and POINT. When `frame_tick` arrives with the counter at 0, the state leaves.
- **IDLE**: any event -> SERVE. Load counter with `SERVE_DELAY_FRAMES`, pulse `ball_reset`.
- **SERVE**: pause event -> PAUSE. Counter expiry -> PLAY.
- **PLAY**: pause event -> PAUSE.
- **PLAY, `miss_left`**: `score_2`+1, `serve_left`<=1.
- **PLAY, `miss_right`**: `score_1`+1, `serve_left`<=0.
- **PLAY, after a miss**: if the new score equals `WIN_SCORE` -> OVER and set `winner`. Otherwise -> POINT and load `POINT_HOLD_FRAMES`.
- **PLAY, both misses in one cycle**: `miss_left` wins; `miss_right` is dropped.
- Misses are ignored in every state other than PLAY.
- **POINT**: counter expiry -> SERVE. Load `SERVE_DELAY_FRAMES`, pulse `ball_reset`. Pause events are ignored.
- **PAUSE**: stores the return state (SERVE or PLAY). A pause event returns to it with the counter unchanged. `frame_tick` and misses are ignored.
- **OVER**: `winner` and scores hold. Any event -> IDLE, clear scores, `winner`<=00, pulse `ball_reset`.
- `run` = (state==PLAY). `paddle_en` = (state==SERVE or PLAY).
- Scores never exceed `WIN_SCORE`; no wrap.

## Timing
- All outputs are registered.
- A `keypressed_x` rising edge sampled at clock edge n gives the new `state`, `run` and `ball_reset` at edge n+1.
- A miss pulse sampled at edge n gives updated scores, `state` and `serve_left` at edge n+1.
- `ball_reset` is high for exactly one cycle per transition into SERVE, or from OVER into IDLE.
- Ball release comes exactly `SERVE_DELAY_FRAMES`+1 `frame_tick`s after entry into SERVE, excluding paused time. A value of 0 means release on the first tick.
- Reset values: `state`=IDLE, `run`=0, `paddle_en`=0, `ball_reset`=0, `serve_left`=0, scores 0, `winner`=00, counter 0.
- Previous-key flops reset to 1, so a key held through reset release produces no event.
- Reset asserted mid-rally forces all of the above immediately, asynchronously.

## Configuration
- `PONG_AUTO_SERVE_EN` defined: counter expiry in SERVE releases the ball automatically, as described above.
- `PONG_AUTO_SERVE_EN` undefined: after counter expiry, SERVE waits for a key event from the serving player before entering PLAY. The serving player is player 1 if `serve_left`=0 and player 2 if `serve_left`=1. Events from the other player are ignored, except pause.

## Test plan
- **Reset and start**: reset, then `keypressed_1` rises with key 4'd2 -> next cycle `state`=1, `ball_reset`=1 for one cycle, `paddle_en`=1, `run`=0.
- **Serve timing** (auto serve, `SERVE_DELAY_FRAMES`=3) -> `run`=1 one cycle after the 4th `frame_tick`. Pause key mid-count, 10 ticks, pause key again -> release still after 4 unpaused ticks.
- **Point flow**: in PLAY, `miss_left` -> `score_2`=1, `serve_left`=1, `state`=3. After `POINT_HOLD_FRAMES`+1 ticks -> `state`=1 with a `ball_reset` pulse.
- **Simultaneous misses**: `miss_left` and `miss_right` in the same cycle -> only `score_2` increments.
- **Game over**: with `WIN_SCORE`=2, two `miss_right` -> `score_1`=2, `winner`=01, `state`=5. Further misses change nothing. Any key -> `state`=0, scores 0, `winner`=00.
- **Manual serve** (macro undefined, `serve_left`=1): after expiry, a player 1 key is ignored; a player 2 key -> `run`=1 next cycle.

Source files
------------

// File: rtl/pong_game_controller_if.sv
// Signal bundle between the Pong game-flow sequencer and its surroundings:
// keypad decoder inputs, miss pulses from the ball logic, and the match
// status / motion-gating outputs consumed by the image generator.
// The clock and reset are plain ports on the controller, not part of this bundle.
interface pong_game_controller_if;
    logic       frame_tick;
    logic [3:0] keys_1;
    logic       keypressed_1;
    logic [3:0] keys_2;
    logic       keypressed_2;
    logic       miss_left;
    logic       miss_right;
    logic       run;
    logic       paddle_en;
    logic       ball_reset;
    logic       serve_left;
    logic [2:0] score_1;
    logic [2:0] score_2;
    logic [1:0] winner;
    logic [2:0] state;

    // Environment side: drives keys, frame ticks and misses.
    modport master (
        output frame_tick, keys_1, keypressed_1, keys_2, keypressed_2,
               miss_left, miss_right,
        input  run, paddle_en, ball_reset, serve_left,
               score_1, score_2, winner, state
    );

    // Controller side.
    modport slave (
        input  frame_tick, keys_1, keypressed_1, keys_2, keypressed_2,
               miss_left, miss_right,
        output run, paddle_en, ball_reset, serve_left,
               score_1, score_2, winner, state
    );
endinterface

// File: rtl/pong_game_controller.sv
// Pong game-flow sequencer: owns the match state, both scores, the serve
// direction and the frame countdowns for serve and post-point hold.
// Build option PONG_AUTO_SERVE_EN: when defined, the ball is released as soon
// as the serve countdown expires; when undefined, the serving player must
// press a key after the countdown has expired.
module pong_game_controller #(
    parameter int         WIN_SCORE          = 7,
    parameter int         SERVE_DELAY_FRAMES = 60,
    parameter int         POINT_HOLD_FRAMES  = 30,
    parameter logic [3:0] PAUSE_KEY          = 4'd5
) (
    input  logic                 CLOCK_25,
    input  logic                 reset_n,
    pong_game_controller_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    localparam logic [7:0] SERVE_LD = 8'(SERVE_DELAY_FRAMES);
    localparam logic [7:0] HOLD_LD  = 8'(POINT_HOLD_FRAMES);
    localparam logic [2:0] WIN_LD   = 3'(WIN_SCORE);

    state_e     state_q, state_d, ret_q, ret_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] score_1_q, score_1_d, score_2_q, score_2_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_left_q, serve_left_d;
    logic       run_q, run_d, paddle_en_q, paddle_en_d, ball_reset_q, ball_reset_d;
    logic       kp_1_prev_q, kp_2_prev_q;

    // Key edge detection: one event per rising edge of each player's valid.
    logic ev_1_s, ev_2_s, any_ev_s, pause_ev_s, serve_ev_s, expire_s, serve_go_s;
    logic [2:0] score_1_inc_s, score_2_inc_s;
    assign ev_1_s     = bus.keypressed_1 & ~kp_1_prev_q;
    assign ev_2_s     = bus.keypressed_2 & ~kp_2_prev_q;
    assign any_ev_s   = ev_1_s | ev_2_s;
    assign pause_ev_s = (ev_1_s && (bus.keys_1 == PAUSE_KEY)) ||
                        (ev_2_s && (bus.keys_2 == PAUSE_KEY));
    assign serve_ev_s = serve_left_q ? ev_2_s : ev_1_s;
    assign expire_s   = bus.frame_tick && (cnt_q == 8'd0);
    // Saturating increments: a score can never pass the winning value.
    assign score_1_inc_s = (score_1_q < WIN_LD) ? (score_1_q + 3'd1) : score_1_q;
    assign score_2_inc_s = (score_2_q < WIN_LD) ? (score_2_q + 3'd1) : score_2_q;

`ifdef PONG_AUTO_SERVE_EN
    assign serve_go_s = expire_s;
`else
    // Set once the serve countdown has run out; the serving player's key then releases the ball.
    logic armed_q, armed_d;
    assign serve_go_s = armed_q && serve_ev_s;

    // Serve-armed flag register.
    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end
`endif

    // Next-state, score, counter and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        score_1_d    = score_1_q;
        score_2_d    = score_2_q;
        winner_d     = winner_q;
        serve_left_d = serve_left_q;
        ball_reset_d = 1'b0;
`ifndef PONG_AUTO_SERVE_EN
        armed_d      = armed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_ev_s) begin
                    state_d      = ST_SERVE;
                    cnt_d        = SERVE_LD;
                    ball_reset_d = 1'b1;
`ifndef PONG_AUTO_SERVE_EN
                    armed_d      = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (pause_ev_s) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_SERVE;
                end else if (serve_go_s) begin
                    state_d = ST_PLAY;
                end else if (bus.frame_tick && (cnt_q != 8'd0)) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
`ifndef PONG_AUTO_SERVE_EN
                    if (expire_s) begin
                        armed_d = 1'b1;
                    end else begin
                        armed_d = armed_q;
                    end
`endif
                    state_d = ST_SERVE;
                end
            end
            ST_PLAY: begin
                // A left miss takes priority; a simultaneous right miss is dropped.
                if (bus.miss_left) begin
                    score_2_d    = score_2_inc_s;
                    serve_left_d = 1'b1;
                    if (score_2_inc_s == WIN_LD) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d = ST_POINT;
                        cnt_d   = HOLD_LD;
                    end
                end else if (bus.miss_right) begin
                    score_1_d    = score_1_inc_s;
                    serve_left_d = 1'b0;
                    if (score_1_inc_s == WIN_LD) begin
                        state_d  = ST_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d = ST_POINT;
                        cnt_d   = HOLD_LD;
                    end
                end else if (pause_ev_s) begin
                    state_d = ST_PAUSE;
                    ret_d   = ST_PLAY;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                if (expire_s) begin
                    state_d      = ST_SERVE;
                    cnt_d        = SERVE_LD;
                    ball_reset_d = 1'b1;
`ifndef PONG_AUTO_SERVE_EN
                    armed_d      = 1'b0;
`endif
                end else if (bus.frame_tick) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = ST_POINT;
                end
            end
            ST_PAUSE: begin
                if (pause_ev_s) begin
                    state_d = ret_q;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_OVER: begin
                if (any_ev_s) begin
                    state_d      = ST_IDLE;
                    score_1_d    = 3'd0;
                    score_2_d    = 3'd0;
                    winner_d     = 2'b00;
                    ball_reset_d = 1'b1;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        run_d       = (state_d == ST_PLAY);
        paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    end

    // State, score, counter, key-history and output registers.
    always_ff @(posedge CLOCK_25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_SERVE;
            cnt_q        <= 8'd0;
            score_1_q    <= 3'd0;
            score_2_q    <= 3'd0;
            winner_q     <= 2'b00;
            serve_left_q <= 1'b0;
            run_q        <= 1'b0;
            paddle_en_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            kp_1_prev_q  <= 1'b1;
            kp_2_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            score_1_q    <= score_1_d;
            score_2_q    <= score_2_d;
            winner_q     <= winner_d;
            serve_left_q <= serve_left_d;
            run_q        <= run_d;
            paddle_en_q  <= paddle_en_d;
            ball_reset_q <= ball_reset_d;
            kp_1_prev_q  <= bus.keypressed_1;
            kp_2_prev_q  <= bus.keypressed_2;
        end
    end

    assign bus.state      = state_q;
    assign bus.run        = run_q;
    assign bus.paddle_en  = paddle_en_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_left = serve_left_q;
    assign bus.score_1    = score_1_q;
    assign bus.score_2    = score_2_q;
    assign bus.winner     = winner_q;
endmodule
